multi_level_tank_ctrl: RTL and testbench
========================================

MULTI_LEVEL_TANK_CTRL -- requirements
Module: multi_level_tank_ctrl

Interface
REQ-001 Parameter N_LEVELS, default 4, SHALL set the number of level sensors and fill inlets (legal range 2..16).
REQ-002 Parameter DEB_CYCLES, default 3, SHALL set the consecutive stable cycles before a sensor vector is accepted (legal range >=1).
REQ-003 Parameter MIN_OFF_CYCLES, default 8, SHALL set the minimum cycles in FULL before refilling may start (legal range >=1).
REQ-004 Parameter LOW_MARK, default N_LEVELS-2, SHALL set the level at or below which refilling resumes (legal range 0..N_LEVELS-1).
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 sense  input  N_LEVELS  SHALL carry the raw level sensors; bit 0 is the lowest, 1 = water present.
REQ-008 fault_clr  input  1  SHALL be a single-cycle request to leave FAULT.
REQ-009 fill_en  output  N_LEVELS  SHALL be the inlet enables, 1 = inlet open.
REQ-010 level  output  $clog2(N_LEVELS+1)  SHALL be the accepted water level, 0..N_LEVELS.
REQ-011 full  output  1  SHALL be high while in state FULL.
REQ-012 fault  output  1  SHALL be high while in state FAULT.

Function
REQ-013 sense SHALL be registered once into s_r; a stability counter SHALL increment each cycle s_r is unchanged and clear on any change.
REQ-014 The accepted vector acc SHALL load s_r on the edge where the counter reaches DEB_CYCLES; the counter SHALL saturate, with no reload until s_r changes.
REQ-015 Latency: a sense change stable from before edge k SHALL update acc at edge k+DEB_CYCLES and all outputs at edge k+DEB_CYCLES+1.
REQ-016 acc is valid only as a thermometer code (ones contiguous from bit 0); level SHALL equal its population count; on an invalid code, level SHALL hold its last value.
REQ-017 The FSM SHALL have states INIT, FILL, FULL and FAULT.
REQ-018 INIT: all outputs 0; on the first acc load, go to FAULT if the code is invalid, FULL if level==N_LEVELS, else FILL.
REQ-019 FILL: fill_en[i]=1 for i < N_LEVELS-level, all others 0; go to FULL when level==N_LEVELS.
REQ-020 FULL: fill_en=0; an off-timer SHALL start at 0 on entry and saturate at MIN_OFF_CYCLES.
REQ-021 FULL SHALL go to FILL only when the off-timer equals MIN_OFF_CYCLES and level<=LOW_MARK (hysteresis); a level above LOW_MARK SHALL keep FULL.
REQ-022 From any state except INIT, an invalid acc code SHALL go to FAULT; this SHALL take priority over every other transition.
REQ-023 FAULT: fill_en=0 and fault=1; exit only on fault_clr=1 with a valid acc, to FULL if level==N_LEVELS, else FILL.
REQ-024 fault_clr with an invalid acc SHALL be ignored; fault_clr outside FAULT SHALL have no effect.
REQ-025 All outputs SHALL be registered; no combinational path from sense to any output.

Reset
REQ-026 While reset=0: state=INIT, s_r=0, acc=0, counters=0, fill_en=0, level=0, full=0, fault=0.
REQ-027 Reset asserted mid-operation SHALL close all inlets immediately (asynchronously).
REQ-028 After release, inlets SHALL stay closed until the first debounced acceptance.

Structure
REQ-029 The state encoding and the thermometer-validity and popcount functions SHALL live in package tank_ctrl_pkg.
REQ-030 The debounce logic (s_r, stability counter, acc) SHALL be sub-module sensor_debounce, parameterised by width and DEB_CYCLES.

Verification (N_LEVELS=4, DEB_CYCLES=3, MIN_OFF_CYCLES=8, LOW_MARK=2)
REQ-031 Reset release, sense=0000 held -> fill_en=0000 until acceptance, then fill_en=1111, level=0, state FILL.
REQ-032 sense 0001->0011->0111->1111, each held 5 cycles -> fill_en 0111, 0011, 0001, then 0000 with full=1.
REQ-033 sense glitch 0011->0111 for 2 cycles, then back to 0011 -> level stays 2, fill_en stays 0011.
REQ-034 In FULL, sense drops to 0111 -> stays FULL; drops to 0011 within 8 cycles of entry -> refill only once the off-timer reaches 8, then fill_en=0011.
REQ-035 sense=0101 held -> fault=1, fill_en=0000; fault_clr while still 0101 -> no change; sense=0001 then fault_clr -> FILL, fill_en=0111.
REQ-036 reset asserted mid-FILL -> fill_en=0000 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/tank_ctrl_pkg.sv
// Shared types and helpers for the multi-level tank controller.
// Latency: combinational helpers only, no state.
// Backpressure: none; pure definitions.
package tank_ctrl_pkg;

    // Widest sensor vector the helpers accept; narrower vectors are zero-extended.
    localparam int MAX_LEVELS = 16;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2,
        ST_FAULT = 2'd3
    } tank_state_t;

    // A thermometer code plus one is a power of two, so it shares no set bit with itself.
    function automatic logic thermo_valid(input logic [MAX_LEVELS-1:0] v);
        logic [MAX_LEVELS-1:0] inc;
        inc = v + 16'd1;
        return ((v & inc) == '0);
    endfunction

    function automatic logic [4:0] popcount(input logic [MAX_LEVELS-1:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_LEVELS; i++) begin
            cnt = cnt + {4'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Registers the raw sensor vector and accepts it after DEB_CYCLES stable cycles.
// Latency: change stable before edge k is accepted at edge k+DEB_CYCLES.
// Backpressure: none; o_acc_vld pulses for one cycle on each acceptance.
module sensor_debounce #(
    parameter int W          = 4,
    parameter int DEB_CYCLES = 3
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_sense,
    output logic [W-1:0] o_acc,
    output logic         o_acc_vld
);

    localparam int             CW    = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]  C_DEB = CW'(DEB_CYCLES);

    logic [W-1:0]  r_s;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_acc;
    logic          r_acc_vld;

    // Sample sensors, count stable cycles, load acc once per stable run (counter saturates).
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s       <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_acc_vld <= 1'b0;
        end else begin
            r_s       <= i_sense;
            r_acc_vld <= 1'b0;
            if (i_sense != r_s) begin
                r_cnt <= '0;
            end else if (r_cnt != C_DEB) begin
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == C_DEB - CW'(1)) begin
                    r_acc     <= r_s;
                    r_acc_vld <= 1'b1;
                end
            end
        end
    end

    assign o_acc     = r_acc;
    assign o_acc_vld = r_acc_vld;

endmodule

// File: rtl/multi_level_tank_ctrl.sv
// Multi-level tank fill controller: debounced level sensing, fill/full hysteresis, fault latch.
// Latency: outputs follow the accepted sensor vector by one cycle (DEB_CYCLES+1 from sense).
// Backpressure: none; fault is held until fault_clr arrives with a valid sensor code.
module multi_level_tank_ctrl
    import tank_ctrl_pkg::*;
#(
    parameter int N_LEVELS       = 4,
    parameter int DEB_CYCLES     = 3,
    parameter int MIN_OFF_CYCLES = 8,
    parameter int LOW_MARK       = N_LEVELS - 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_LEVELS-1:0]             sense,
    input  logic                            fault_clr,
    output logic [N_LEVELS-1:0]             fill_en,
    output logic [$clog2(N_LEVELS+1)-1:0]   level,
    output logic                            full,
    output logic                            fault
);

    localparam int            LW    = $clog2(N_LEVELS + 1);
    localparam int            TW    = $clog2(MIN_OFF_CYCLES + 1);
    localparam logic [TW-1:0] C_OFF = TW'(MIN_OFF_CYCLES);

    logic [N_LEVELS-1:0]   w_acc;
    logic                  w_acc_vld;
    logic [MAX_LEVELS-1:0] w_acc_ext;
    logic                  w_valid;
    logic [LW-1:0]         w_pop;
    logic                  w_is_full;
    logic                  w_low;
    logic [N_LEVELS-1:0]   w_fill_mask;
    tank_state_t           w_next;

    tank_state_t           r_state;
    logic [TW-1:0]         r_off;
    logic [N_LEVELS-1:0]   r_fill_en;
    logic [LW-1:0]         r_level;
    logic                  r_full;
    logic                  r_fault;

    sensor_debounce #(
        .W          (N_LEVELS),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .i_rst_n   (reset),
        .i_sense   (sense),
        .o_acc     (w_acc),
        .o_acc_vld (w_acc_vld)
    );

    assign w_acc_ext = MAX_LEVELS'(w_acc);
    assign w_valid   = thermo_valid(w_acc_ext);
    assign w_pop     = LW'(popcount(w_acc_ext));
    assign w_is_full = (w_pop == LW'(N_LEVELS));
    assign w_low     = (w_pop <= LW'(LOW_MARK));

    // Open the inlets above the current water line: bits below N_LEVELS-level.
    always_comb begin
        w_fill_mask = '0;
        for (int i = 0; i < N_LEVELS; i++) begin
            if (i < N_LEVELS - int'(w_pop)) begin
                w_fill_mask[i] = 1'b1;
            end
        end
    end

    // Next-state selection; an invalid code outranks every other transition once out of INIT.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT: begin
                if (w_acc_vld) begin
                    if (!w_valid)       w_next = ST_FAULT;
                    else if (w_is_full) w_next = ST_FULL;
                    else                w_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (!w_valid)       w_next = ST_FAULT;
                else if (w_is_full) w_next = ST_FULL;
            end
            ST_FULL: begin
                if (!w_valid)                      w_next = ST_FAULT;
                else if ((r_off == C_OFF) && w_low) w_next = ST_FILL;
            end
            default: begin
                if (w_valid && fault_clr) begin
                    w_next = w_is_full ? ST_FULL : ST_FILL;
                end
            end
        endcase
    end

    // State, off-timer and registered outputs; reset closes all inlets asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_INIT;
            r_off     <= '0;
            r_fill_en <= '0;
            r_level   <= '0;
            r_full    <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_fill_en <= (w_next == ST_FILL) ? w_fill_mask : '0;
            r_full    <= (w_next == ST_FULL);
            r_fault   <= (w_next == ST_FAULT);
            if (w_valid) begin
                r_level <= w_pop;
            end
            // Timer restarts at 0 on entry to FULL and saturates while resident.
            if (r_state != ST_FULL) begin
                r_off <= '0;
            end else if (r_off != C_OFF) begin
                r_off <= r_off + TW'(1);
            end
        end
    end

    assign fill_en = r_fill_en;
    assign level   = r_level;
    assign full    = r_full;
    assign fault   = r_fault;

endmodule

// File: tb/tb_multi_level_tank_ctrl.sv
// Testbench for multi_level_tank_ctrl: directed scenarios plus randomized sensor traffic.
// Latency: expectations come from a history-based reference model evaluated per clock edge.
// Backpressure: none.
module tb_multi_level_tank_ctrl;

    localparam int N       = 4;
    localparam int DEB     = 3;
    localparam int MIN_OFF = 8;
    localparam int LOW     = 2;

    localparam int M_INIT  = 0;
    localparam int M_FILL  = 1;
    localparam int M_FULL  = 2;
    localparam int M_FAULT = 3;

    logic         clk;
    logic         reset;
    logic [N-1:0] sense;
    logic         fault_clr;
    logic [N-1:0] fill_en;
    logic [2:0]   level;
    logic         full;
    logic         fault;

    int n_cmp;
    int n_err;

    // Reference model state
    int hist[$];
    int m_acc;
    bit m_load;
    int m_state;
    int m_in_full;
    int m_level;
    int m_fill;
    int m_full;
    int m_fault;

    multi_level_tank_ctrl #(
        .N_LEVELS       (N),
        .DEB_CYCLES     (DEB),
        .MIN_OFF_CYCLES (MIN_OFF),
        .LOW_MARK       (LOW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sense     (sense),
        .fault_clr (fault_clr),
        .fill_en   (fill_en),
        .level     (level),
        .full      (full),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic bit is_thermo(input int v);
        bit seen_zero;
        seen_zero = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (v[i] == 1'b0) seen_zero = 1'b1;
            else if (seen_zero) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(0);
        m_acc     = 0;
        m_load    = 1'b0;
        m_state   = M_INIT;
        m_in_full = 0;
        m_level   = 0;
        m_fill    = 0;
        m_full    = 0;
        m_fault   = 0;
    endtask

    // One rising edge: controller reacts to the vector accepted before the edge,
    // then the sampled-sensor history decides whether a new vector is accepted.
    task automatic model_edge(input int s, input bit clr);
        bit ok;
        int pop;
        int ns;
        int run;
        ok  = is_thermo(m_acc);
        pop = $countones(m_acc);
        ns  = m_state;
        case (m_state)
            M_INIT:  if (m_load) ns = !ok ? M_FAULT : ((pop == N) ? M_FULL : M_FILL);
            M_FILL:  if (!ok) ns = M_FAULT; else if (pop == N) ns = M_FULL;
            M_FULL:  if (!ok) ns = M_FAULT; else if (m_in_full >= MIN_OFF && pop <= LOW) ns = M_FILL;
            default: if (ok && clr) ns = (pop == N) ? M_FULL : M_FILL;
        endcase
        if (ns == M_FULL) m_in_full = (m_state == M_FULL) ? m_in_full + 1 : 0;
        if (ok) m_level = pop;
        m_fill  = (ns == M_FILL) ? ((1 << (N - pop)) - 1) : 0;
        m_full  = (ns == M_FULL) ? 1 : 0;
        m_fault = (ns == M_FAULT) ? 1 : 0;
        m_state = ns;

        hist.push_back(s);
        if (hist.size() > DEB + 2) void'(hist.pop_front());
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == s) run++;
            else break;
        end
        m_load = (run == DEB + 1);
        if (m_load) m_acc = s;
    endtask

    task automatic compare_model();
        check_eq("fill_en", 32'(fill_en), m_fill);
        check_eq("level",   32'(level),   m_level);
        check_eq("full",    32'(full),    m_full);
        check_eq("fault",   32'(fault),   m_fault);
    endtask

    // Called at a falling edge; drives inputs, advances one cycle, checks at the next falling edge.
    task automatic step(input int s, input bit clr);
        sense     = 4'(s);
        fault_clr = clr;
        @(posedge clk);
        model_edge(s, clr);
        @(negedge clk);
        compare_model();
    endtask

    task automatic hold(input int s, input int n);
        for (int c = 0; c < n; c++) step(s, 1'b0);
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        #1;
        check_eq("async_rst_fill", 32'(fill_en), 0);
        check_eq("async_rst_full", 32'(full), 0);
        check_eq("async_rst_fault", 32'(fault), 0);
        check_eq("async_rst_level", 32'(level), 0);
        @(posedge clk);
        @(negedge clk);
        model_reset();
        compare_model();
        reset = 1'b1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        sense     = '0;
        fault_clr = 1'b0;
        model_reset();
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_fill", 32'(fill_en), 0);
        check_eq("rst_level", 32'(level), 0);
        check_eq("rst_full", 32'(full), 0);
        check_eq("rst_fault", 32'(fault), 0);
        reset = 1'b1;

        // Empty tank after release: closed until acceptance, then all inlets open.
        hold(0, 3);
        check_eq("pre_accept_fill", 32'(fill_en), 0);
        hold(0, 1);
        check_eq("first_fill", 32'(fill_en), 32'hF);
        check_eq("first_level", 32'(level), 0);

        // Rising water closes inlets top-down.
        hold(1, 5);
        check_eq("lvl1_fill", 32'(fill_en), 32'h7);
        hold(3, 5);
        check_eq("lvl2_fill", 32'(fill_en), 32'h3);
        hold(7, 5);
        check_eq("lvl3_fill", 32'(fill_en), 32'h1);
        hold(15, 5);
        check_eq("lvl4_fill", 32'(fill_en), 0);
        check_eq("lvl4_full", 32'(full), 1);
        check_eq("lvl4_level", 32'(level), 4);

        // Level above the low mark keeps FULL.
        hold(7, 12);
        check_eq("hyst_full", 32'(full), 1);
        check_eq("hyst_level", 32'(level), 3);
        hold(3, 6);
        check_eq("refill_fill", 32'(fill_en), 32'h3);

        // Short glitch never gets accepted.
        hold(7, 2);
        hold(3, 6);
        check_eq("glitch_level", 32'(level), 2);
        check_eq("glitch_fill", 32'(fill_en), 32'h3);

        // Early drop in FULL waits for the off-timer.
        hold(15, 5);
        check_eq("timer_entry_full", 32'(full), 1);
        hold(3, 8);
        check_eq("timer_wait_full", 32'(full), 1);
        hold(3, 1);
        check_eq("timer_expire_fill", 32'(fill_en), 32'h3);
        check_eq("timer_expire_full", 32'(full), 0);

        // Invalid code latches fault; clear only honoured with a valid code.
        hold(5, 5);
        check_eq("fault_set", 32'(fault), 1);
        check_eq("fault_fill", 32'(fill_en), 0);
        step(5, 1'b1);
        hold(5, 3);
        check_eq("fault_clr_ignored", 32'(fault), 1);
        hold(1, 5);
        check_eq("fault_held", 32'(fault), 1);
        step(1, 1'b1);
        check_eq("fault_exit", 32'(fault), 0);
        check_eq("fault_exit_fill", 32'(fill_en), 32'h7);

        // Reset in the middle of filling.
        hold(1, 2);
        reset_pulse();

        // Randomized traffic: mostly valid levels, some corrupt codes, random clears and resets.
        for (int seg = 0; seg < 300; seg++) begin
            int lvl;
            int s;
            int len;
            if ($urandom_range(0, 39) == 0) reset_pulse();
            lvl = int'($urandom_range(0, N));
            s   = (1 << lvl) - 1;
            if ($urandom_range(0, 5) == 0) s = int'($urandom_range(0, 15));
            len = int'($urandom_range(1, 14));
            for (int c = 0; c < len; c++) step(s, ($urandom_range(0, 5) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
